// File: rtl/code_entry_fsm.sv
// Access-code entry stage behind the keypad scanner: debounces raw key-down into single
// key events, collects up to four BCD digits, checks them on ENTER and drives
// door-open / error / lockout outputs from one shared down-counting timer.
module code_entry_fsm #(
  parameter int unsigned DEB_CYCLES  = 20,
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int unsigned OPEN_CYCLES = 3000,
  parameter int unsigned ERR_CYCLES  = 500,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_num,
  input  logic        key_down,
  output logic [15:0] digits,
  output logic [2:0]  n_digits,
  output logic        door_open,
  output logic        err,
  output logic        locked,
  output logic [1:0]  fails
);

  localparam int unsigned MaxOe  = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
  localparam int unsigned MaxDur = (MaxOe > LOCK_CYCLES) ? MaxOe : LOCK_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxDur) + 1;
  localparam int unsigned DebW   = $clog2(DEB_CYCLES + 1);

  localparam logic [DebW-1:0]   DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [TimerW-1:0] OpenLd   = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] ErrLd    = TimerW'(ERR_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLd   = TimerW'(LOCK_CYCLES - 1);
  localparam logic [1:0]        MaxFails = 2'(MAX_FAILS);

  localparam logic [3:0] KeyEnter = 4'hA;
  localparam logic [3:0] KeyClear = 4'hB;

  typedef enum logic {DbReleased, DbPressed} db_state_e;
  typedef enum logic [2:0] {StIdle, StEntry, StCheck, StOpen, StFail, StLocked} state_e;

  db_state_e         db_state_q, db_state_d;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
  logic              evt_q, evt_d;
  logic [3:0]        evt_key_q, evt_key_d;

  state_e            state_q, state_d;
  logic [15:0]       digits_q, digits_d;
  logic [2:0]        n_digits_q, n_digits_d;
  logic              door_open_q, door_open_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic [1:0]        fails_q, fails_d;
  logic [1:0]        fails_inc;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              is_digit;

  assign is_digit  = (evt_key_q <= 4'd9);
  assign fails_inc = (fails_q == MaxFails) ? fails_q : fails_q + 2'd1;

  // Debouncer: one event per press, released only after a stable low run.
  always_comb begin
    db_state_d = db_state_q;
    deb_cnt_d  = deb_cnt_q;
    evt_d      = 1'b0;
    evt_key_d  = evt_key_q;
    case (db_state_q)
      DbReleased: begin
        if (!key_down) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          evt_d      = 1'b1;
          evt_key_d  = key_num;
          deb_cnt_d  = '0;
          db_state_d = DbPressed;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: begin
        if (key_down) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          deb_cnt_d  = '0;
          db_state_d = DbReleased;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Main FSM next state: events are only acted on in IDLE and ENTRY.
  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    n_digits_d  = n_digits_q;
    door_open_d = door_open_q;
    err_d       = err_q;
    locked_d    = locked_q;
    fails_d     = fails_q;
    timer_d     = timer_q;
    case (state_q)
      StIdle: begin
        if (evt_q && is_digit) begin
          digits_d   = {12'hFFF, evt_key_q};
          n_digits_d = 3'd1;
          state_d    = StEntry;
        end
      end
      StEntry: begin
        if (evt_q) begin
          if (is_digit) begin
            if (n_digits_q < 3'd4) begin
              digits_d   = {digits_q[11:0], evt_key_q};
              n_digits_d = n_digits_q + 3'd1;
            end
          end else if (evt_key_q == KeyEnter) begin
            state_d = StCheck;
          end else if (evt_key_q == KeyClear) begin
            digits_d   = 16'hFFFF;
            n_digits_d = 3'd0;
            state_d    = StIdle;
          end
        end
      end
      StCheck: begin
        digits_d   = 16'hFFFF;
        n_digits_d = 3'd0;
        if (n_digits_q == 3'd4 && digits_q == CODE) begin
          fails_d     = 2'd0;
          door_open_d = 1'b1;
          timer_d     = OpenLd;
          state_d     = StOpen;
        end else begin
          fails_d = fails_inc;
          err_d   = 1'b1;
          if (fails_inc == MaxFails) begin
            locked_d = 1'b1;
            timer_d  = LockLd;
            state_d  = StLocked;
          end else begin
            timer_d = ErrLd;
            state_d = StFail;
          end
        end
      end
      StOpen: begin
        if (timer_q == '0) begin
          door_open_d = 1'b0;
          state_d     = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StFail: begin
        if (timer_q == '0) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StLocked: begin
        if (timer_q == '0) begin
          err_d    = 1'b0;
          locked_d = 1'b0;
          fails_d  = 2'd0;
          state_d  = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_state_q  <= DbReleased;
      deb_cnt_q   <= '0;
      evt_q       <= 1'b0;
      evt_key_q   <= 4'h0;
      state_q     <= StIdle;
      digits_q    <= 16'hFFFF;
      n_digits_q  <= 3'd0;
      door_open_q <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      fails_q     <= 2'd0;
      timer_q     <= '0;
    end else begin
      db_state_q  <= db_state_d;
      deb_cnt_q   <= deb_cnt_d;
      evt_q       <= evt_d;
      evt_key_q   <= evt_key_d;
      state_q     <= state_d;
      digits_q    <= digits_d;
      n_digits_q  <= n_digits_d;
      door_open_q <= door_open_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      fails_q     <= fails_d;
      timer_q     <= timer_d;
    end
  end

  assign digits    = digits_q;
  assign n_digits  = n_digits_q;
  assign door_open = door_open_q;
  assign err       = err_q;
  assign locked    = locked_q;
  assign fails     = fails_q;

endmodule
